// File: rtl/program_memory_loader.sv
// Program memory loader: assembles a little-endian byte stream into instruction
// words and writes them to consecutive program-memory addresses.
module program_memory_loader #(
  parameter int MEMORY_DEPTH = 64,
  parameter int DATA_WIDTH   = 32,
  localparam int AW          = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [AW:0]           length_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  we_o,
  output logic [AW-1:0]         waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [AW:0]           word_count_o
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [AW:0]    DEPTH_L   = (AW + 1)'(MEMORY_DEPTH);
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [AW:0]    len_q, len_d;
  logic [AW:0]    count_q, count_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [BIW-1:0] idx_q, idx_d;
  logic           error_q, error_d;
  logic           accept;

  assign accept = (state_q == RECV) && byte_valid_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (length_i > DEPTH_L) begin
            error_d = 1'b1;
          end else begin
            error_d = 1'b0;
            len_d   = length_i;
            count_d = '0;
            addr_d  = '0;
            idx_d   = '0;
            state_d = (length_i == '0) ? DONE : RECV;
          end
        end
      end
      RECV: begin
        if (byte_valid_i) begin
          if (idx_q == LAST_BYTE) begin
            state_d = WRITE;
          end else begin
            idx_d = idx_q + BIW'(1);
          end
        end
      end
      WRITE: begin
        count_d = count_q + (AW + 1)'(1);
        idx_d   = '0;
        // The address stops at the last written word so a full load never wraps.
        if (count_q + (AW + 1)'(1) == len_q) begin
          state_d = DONE;
        end else begin
          state_d = RECV;
          addr_d  = addr_q + AW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One byte lane per generate iteration; lane k captures the k-th byte of a word.
  for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
    logic [7:0] lane_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        lane_q <= '0;
      end else if (accept && (idx_q == BIW'(gi))) begin
        lane_q <= byte_i;
      end
    end
    assign wdata_o[8*gi +: 8] = lane_q;
  end

  assign byte_ready_o = (state_q == RECV);
  assign we_o         = (state_q == WRITE);
  assign done_o       = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign waddr_o      = addr_q;
  assign error_o      = error_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed self-checking bench for program_memory_loader (64 x 32-bit target).
module tb_program_memory_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [6:0]  length_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        we_o;
  logic [5:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [6:0]  word_count_o;

  program_memory_loader #(.MEMORY_DEPTH(64), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .length_i     (length_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .word_count_o (word_count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_acc = 0;

  logic [5:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cnt  = 0;
  int          done_cyc  = 0;
  int          busy_cnt  = 0;
  int          ready_in_write = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we_o) begin
      wr_addr.push_back(waddr_o);
      wr_data.push_back(wdata_o);
      wr_cyc.push_back(cyc);
      $display("write addr=%0d data=0x%08h cycle=%0d", waddr_o, wdata_o, cyc);
      if (byte_ready_o) ready_in_write++;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_o) busy_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    busy_cnt = 0;
    ready_in_write = 0;
  endtask

  task automatic start_load(input int len);
    start_i  = 1'b1;
    length_i = 7'(len);
    @(negedge clk);
    start_i  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    while (!byte_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", byte_ready_o, 1);
    byte_valid_i = 1'b1;
    byte_i       = b;
    @(negedge clk);
    byte_valid_i = 1'b0;
    last_acc     = cyc;
    if (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_o, 1);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pat(input int w);
    return {8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1), 8'(4*w)};
  endfunction

  initial begin
    reset        = 1'b1;
    start_i      = 1'b0;
    length_i     = '0;
    byte_i       = '0;
    byte_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_we", we_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_count", word_count_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // Two-word load with the reference byte stream
    clear_log();
    start_load(2);
    send_word(32'h0000_0513);
    send_word(32'h0010_0593);
    check("t1_latency_we", we_o, 1);
    check("t1_ready_in_write", byte_ready_o, 0);
    wait_done(50);
    check("t1_nwrites", wr_addr.size(), 2);
    check("t1_addr0", wr_addr[0], 0);
    check("t1_data0", wr_data[0], 32'h0000_0513);
    check("t1_addr1", wr_addr[1], 1);
    check("t1_data1", wr_data[1], 32'h0010_0593);
    check("t1_we_cycle", wr_cyc[1], last_acc);
    check("t1_done_cycle", done_cyc, wr_cyc[1] + 1);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_word_count", word_count_o, 2);
    check("t1_busy_idle", busy_o, 0);

    // Zero-length load
    clear_log();
    start_load(0);
    check("t2_done", done_o, 1);
    repeat (3) @(negedge clk);
    check("t2_busy_cycles", busy_cnt, 1);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_nwrites", wr_addr.size(), 0);

    // Oversized length rejected, then cleared by an accepted start
    clear_log();
    start_load(65);
    check("t3_error", error_o, 1);
    check("t3_busy", busy_o, 0);
    repeat (3) @(negedge clk);
    check("t3_error_hold", error_o, 1);
    check("t3_nwrites", wr_addr.size(), 0);
    check("t3_busy_cycles", busy_cnt, 0);
    start_load(1);
    check("t3_error_clr", error_o, 0);
    check("t3_busy_after", busy_o, 1);
    send_word(32'hDEAD_BEEF);
    wait_done(50);
    check("t3_data", wr_data[0], 32'hDEAD_BEEF);
    check("t3_word_count", word_count_o, 1);

    // Gapped byte stream with a stray start pulse mid-load
    clear_log();
    start_load(1);
    for (int k = 0; k < 4; k++) begin
      send_byte(8'(32'hA1B2_C3D4 >> (8*k)), 1'b0);
      if (k == 1) begin
        start_i  = 1'b1;
        length_i = 7'd5;
      end
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_done(50);
    repeat (3) @(negedge clk);
    check("t4_nwrites", wr_addr.size(), 1);
    check("t4_data", wr_data[0], 32'hA1B2_C3D4);
    check("t4_word_count", word_count_o, 1);
    check("t4_ready_in_write", ready_in_write, 0);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_busy_idle", busy_o, 0);

    // Reset in the middle of the fourth word
    clear_log();
    start_load(4);
    for (int w = 0; w < 3; w++) send_word(32'h0101_0101 * (w + 1));
    send_byte(8'h77, 1'b0);
    send_byte(8'h66, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("t5_we", we_o, 0);
    check("t5_waddr", waddr_o, 0);
    check("t5_wdata", wdata_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_ready", byte_ready_o, 0);
    check("t5_count", word_count_o, 0);
    check("t5_error", error_o, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_nwrites", wr_addr.size(), 3);
    check("t5_no_done", done_cnt, 0);
    clear_log();
    start_load(1);
    send_word(32'h55AA_33CC);
    wait_done(50);
    check("t5_restart_addr", wr_addr[0], 0);
    check("t5_restart_data", wr_data[0], 32'h55AA_33CC);

    // Full-depth load
    clear_log();
    start_load(64);
    for (int w = 0; w < 64; w++) send_word(pat(w));
    wait_done(100);
    begin
      int bad = 0;
      for (int w = 0; w < wr_addr.size(); w++)
        if (wr_addr[w] !== 6'(w) || wr_data[w] !== pat(w)) bad++;
      check("t6_sequence", bad, 0);
    end
    check("t6_nwrites", wr_addr.size(), 64);
    check("t6_last_addr", wr_addr[63], 63);
    check("t6_last_data", wr_data[63], 32'hFFFE_FDFC);
    check("t6_word_count", word_count_o, 64);
    check("t6_waddr_hold", waddr_o, 63);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
